// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// regfile_pkg : shared types, defaults and helpers for the regfile_mp block
// Revision    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package regfile_pkg;

  typedef enum logic [0:0] {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Smallest n with 2**n >= value; evaluated at elaboration for address widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
//------------------------------------------------------------------------------
// regfile_read_port : one read port, zero/bypass/array priority mux + output reg
// Revision          : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module regfile_read_port #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [AW-1:0]   rs_i,
  input  logic [XLEN-1:0] arr_data_i,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  output logic [XLEN-1:0] regval_o
);

  logic [XLEN-1:0] regval_q;
  logic [XLEN-1:0] regval_d;
  logic            bypass_hit;
  logic            zero_hit;

  generate
    if (BYPASS != 0) begin : g_bypass
      assign bypass_hit = wr_en_i && (wr_addr_i == rs_i);
    end else begin : g_no_bypass
      logic unused_bypass;
      assign bypass_hit    = 1'b0;
      assign unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i};
    end

    if (ZERO_REG != 0) begin : g_zero
      assign zero_hit = (rs_i == '0);
    end else begin : g_no_zero
      assign zero_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    regval_d = regval_q;
    if (en_i) begin
      if (zero_hit) begin
        regval_d = '0;
      end else if (bypass_hit) begin
        regval_d = wr_data_i;
      end else begin
        regval_d = arr_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regval_q <= '0;
    end else begin
      regval_q <= regval_d;
    end
  end

  assign regval_o = regval_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
//------------------------------------------------------------------------------
// regfile_mp : parametrised multi-read-port register file with post-reset scrub
// Revision   : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic                I_re,
  input  logic [NRD*AW-1:0]   I_rs,
  input  logic                I_we,
  input  logic [AW-1:0]       I_rd,
  input  logic [XLEN-1:0]     I_data,
  output logic [NRD*XLEN-1:0] O_regval,
  output logic                O_ready,
  output logic [NREGS-1:0]    O_zero_flags
);

  state_e          state_q;
  state_e          state_d;
  logic [AW-1:0]   ptr_q;
  logic [AW-1:0]   ptr_d;
  logic [XLEN-1:0] mem_q [NREGS];

  logic run;
  logic wr_eff;
  logic rd_en;
  logic wr_run;

  assign run    = (state_q == RUN);
  assign wr_eff = I_we && !((ZERO_REG != 0) && (I_rd == '0));
  assign rd_en  = run && I_re;
  assign wr_run = run && wr_eff;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == SCRUB) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == AW'(NREGS - 1)) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= SCRUB;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The reset edge leaves the array alone; the scrub walk clears it afterwards.
  always @(posedge I_clk) begin
    if (!I_rst) begin
      if (state_q == SCRUB) begin
        mem_q[ptr_q] <= '0;
      end else if (wr_eff) begin
        mem_q[I_rd] <= I_data;
      end
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      regfile_read_port #(
        .XLEN     (XLEN),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
      ) u_port (
        .clk_i      (I_clk),
        .rst_i      (I_rst),
        .en_i       (rd_en),
        .rs_i       (I_rs[k*AW +: AW]),
        .arr_data_i (mem_q[I_rs[k*AW +: AW]]),
        .wr_en_i    (wr_run),
        .wr_addr_i  (I_rd),
        .wr_data_i  (I_data),
        .regval_o   (O_regval[k*XLEN +: XLEN])
      );
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_flag
      if ((i == 0) && (ZERO_REG != 0)) begin : g_hard
        assign O_zero_flags[i] = 1'b1;
      end else begin : g_arr
        assign O_zero_flags[i] = (mem_q[i] == '0);
      end
    end
  endgenerate

  assign O_ready = run;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
//------------------------------------------------------------------------------
// tb_regfile_mp : two regfile_mp configurations driven together against a model
// Revision      : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_mp;

  typedef struct packed {
    logic         rdy_a;
    logic         rdy_b;
    logic [63:0]  rv_a;
    logic [255:0] rv_b;
    logic [31:0]  fl_a;
    logic [15:0]  fl_b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, re, we;
  logic [4:0]     rd;
  logic [63:0]    data;
  logic [3:0][4:0] rs;

  logic [63:0]  rv_a;
  logic [255:0] rv_b;
  logic         rdy_a, rdy_b;
  logic [31:0]  fl_a;
  logic [15:0]  fl_b;

  // A: default config. B: wide, shallow, four ports, no x0, no bypass.
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .I_clk(clk), .I_rst(rst), .I_re(re), .I_rs({rs[1], rs[0]}), .I_we(we),
    .I_rd(rd), .I_data(data[31:0]), .O_regval(rv_a), .O_ready(rdy_a),
    .O_zero_flags(fl_a)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .I_clk(clk), .I_rst(rst), .I_re(re),
    .I_rs({rs[3][3:0], rs[2][3:0], rs[1][3:0], rs[0][3:0]}), .I_we(we),
    .I_rd(rd[3:0]), .I_data(data), .O_regval(rv_b), .O_ready(rdy_b),
    .O_zero_flags(fl_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  // Reference model state: array contents, entries scrubbed so far, read outputs.
  logic [63:0] m_mem [2][32];
  int          m_done [2];
  logic [63:0] m_rv [2][4];

  function automatic int cfg_n(input int c);
    return (c == 0) ? 32 : 16;
  endfunction

  task automatic model_step();
    int n, nrd, wa, ra;
    bit z, bp, ew;
    logic [63:0] msk;
    for (int c = 0; c < 2; c++) begin
      n   = cfg_n(c);
      nrd = (c == 0) ? 2 : 4;
      z   = (c == 0);
      bp  = (c == 0);
      msk = (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      if (rst) begin
        m_done[c] = 0;
        for (int k = 0; k < 4; k++) m_rv[c][k] = '0;
      end else if (m_done[c] < n) begin
        m_mem[c][m_done[c]] = '0;
        m_done[c]++;
      end else begin
        wa = int'(rd) % n;
        ew = we && !(z && wa == 0);
        if (re) begin
          for (int k = 0; k < nrd; k++) begin
            ra = int'(rs[k]) % n;
            if (z && ra == 0)             m_rv[c][k] = '0;
            else if (bp && ew && wa == ra) m_rv[c][k] = data & msk;
            else                           m_rv[c][k] = m_mem[c][ra];
          end
        end
        if (ew) m_mem[c][wa] = data & msk;
      end
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.rdy_a = (m_done[0] == 32);
    e.rdy_b = (m_done[1] == 16);
    e.rv_a  = {m_rv[0][1][31:0], m_rv[0][0][31:0]};
    e.rv_b  = {m_rv[1][3], m_rv[1][2], m_rv[1][1], m_rv[1][0]};
    for (int i = 0; i < 32; i++) e.fl_a[i] = (m_mem[0][i] == 64'd0) || (i == 0);
    for (int i = 0; i < 16; i++) e.fl_b[i] = (m_mem[1][i] == 64'd0);
    return e;
  endfunction

  task automatic tick();
    model_step();
    exp_q.push_back(model_expect());
    @(posedge clk);
    #2;
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      dut_a.mem_q[i] = 32'hDEADBEEF;
      m_mem[0][i]    = 64'h0000_0000_DEAD_BEEF;
    end
    for (int i = 0; i < 16; i++) begin
      dut_b.mem_q[i] = 64'hDEADBEEF_DEADBEEF;
      m_mem[1][i]    = 64'hDEADBEEF_DEADBEEF;
    end
  endtask

  task automatic rand_rw();
    we   = 1'($urandom);
    re   = 1'($urandom);
    rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    data = {$urandom, $urandom};
    for (int k = 0; k < 4; k++)
      rs[k] = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
  endtask

  task automatic sweep();
    we = 1'b0;
    re = 1'b1;
    for (int a = 0; a < 32; a++) begin
      for (int k = 0; k < 4; k++) rs[k] = 5'(a + k);
      tick();
    end
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ready_a", 256'(rdy_a), 256'(e.rdy_a));
        check("ready_b", 256'(rdy_b), 256'(e.rdy_b));
        check("regval_a", 256'(rv_a), 256'(e.rv_a));
        check("regval_b", rv_b, e.rv_b);
        check("zflags_a", 256'(fl_a), 256'(e.fl_a));
        check("zflags_b", 256'(fl_b), 256'(e.fl_b));
      end
    end
  end

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; rd = '0; data = '0; rs = '0;
    for (int k = 0; k < 4; k++) begin
      m_rv[0][k] = '0;
      m_rv[1][k] = '0;
    end
    m_done[0] = 0;
    m_done[1] = 0;
    preload();
    tick();
    rst = 1'b0;

    // Restart the scrub part-way; traffic during scrub must leave no trace.
    repeat (10) begin rand_rw(); tick(); end
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (15) begin rand_rw(); tick(); end
    we = 1'b0; re = 1'b0;
    repeat (17) tick();
    sweep();

    we = 1'b1; rd = 5'd5; data = 64'hCAFEF00D_12345678; re = 1'b0; tick();
    we = 1'b0; re = 1'b1; rs[0] = 5'd5; rs[1] = 5'd0; rs[2] = 5'd5; rs[3] = 5'd5; tick();

    re = 1'b0; we = 1'b1; rd = 5'd7; data = 64'h1; tick();
    we = 1'b1; rd = 5'd7; data = 64'h5A5A5A5A_A5A5A5A5; re = 1'b1;
    rs[0] = 5'd7; rs[1] = 5'd7; rs[2] = 5'd3; rs[3] = 5'd7; tick();
    we = 1'b0; tick();

    we = 1'b1; rd = 5'd0; data = 64'hFFFF_FFFF_FFFF_FFFF; re = 1'b0; tick();
    we = 1'b0; re = 1'b1; rs = '0; tick();

    re = 1'b0;
    repeat (3) begin
      we = 1'b1; rd = 5'($urandom); data = {$urandom, $urandom}; tick();
    end

    repeat (400) begin
      rand_rw();
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    rst = 1'b0; we = 1'b0; re = 1'b0;
    while (m_done[0] < 32 || m_done[1] < 16) tick();
    preload();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (32) tick();
    sweep();

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending records, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
